// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase scheduler.
// Holds the phase enum and the round-robin approach selector.
package traffic_pkg;

  typedef enum logic [1:0] {
    StGreen,
    StYellow,
    StAllRed,
    StWalk
  } state_t;

  localparam int unsigned HomeIdx = 0;
  localparam int unsigned MaxApp  = 32;
  localparam int unsigned IdxW    = 5;

  // First pending approach after cur (cur itself scanned last); home when none pending.
  function automatic int unsigned rr_next(input logic [MaxApp-1:0] pend,
                                          input int unsigned cur,
                                          input int unsigned n_app);
    int unsigned idx;
    logic        found;
    rr_next = HomeIdx;
    found   = 1'b0;
    for (int unsigned k = 1; k <= MaxApp; k++) begin
      if (k <= n_app) begin
        idx = (cur + k) % n_app;
        if (!found && pend[idx[IdxW-1:0]]) begin
          found   = 1'b1;
          rr_next = idx;
        end
      end
    end
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase duration counter: synchronous clear, count enable, saturates at all-ones.
module phase_timer #(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [TW-1:0] cnt
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Round-robin signal scheduler for N_APP approaches plus a pedestrian walk phase.
// Approach 0 is the rest approach; lamps decode from registered state only.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned N_APP  = 4,
  parameter int unsigned TW     = 8,
  parameter int unsigned MIN_G  = 10,
  parameter int unsigned MAX_G  = 40,
  parameter int unsigned Y_T    = 4,
  parameter int unsigned AR_T   = 2,
  parameter int unsigned WALK_T = 12,
  localparam int unsigned PW    = (N_APP > 1) ? $clog2(N_APP) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_APP-1:0] req,
  input  logic             ped_req,
  output logic [N_APP-1:0] green,
  output logic [N_APP-1:0] yellow,
  output logic [N_APP-1:0] red,
  output logic             walk,
  output logic [PW-1:0]    phase
);

  state_t             state_q, state_d;
  logic [PW-1:0]      cur_q, cur_d;
  logic [N_APP-1:0]   pend_q, pend_d;
  logic               ped_pend_q, ped_pend_d;
  logic [TW-1:0]      cnt;
  logic [N_APP-1:0]   cur_mask;
  logic [MaxApp-1:0]  pend_ext;
  logic [PW-1:0]      next_idx;
  logic               competing;
  logic               leave_green;
  logic               enter_green;
  logic               enter_walk;
  logic               cnt_clr;

  phase_timer #(
    .TW (TW)
  ) u_phase_timer (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (1'b1),
    .cnt (cnt)
  );

  always_comb begin
    cur_mask        = '0;
    cur_mask[cur_q] = 1'b1;
    pend_ext                = '0;
    pend_ext[N_APP-1:0]     = pend_q;
    next_idx  = PW'(rr_next(pend_ext, 32'(cur_q), N_APP));
    competing = (|(pend_q & ~cur_mask)) | ped_pend_q;
    // Release early once the served approach empties; force off at max green otherwise.
    leave_green = (cnt >= TW'(MIN_G - 1)) && competing &&
                  (!(|(req & cur_mask)) || (cnt >= TW'(MAX_G - 1)));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StGreen:  if (leave_green) state_d = StYellow;
      StYellow: if (cnt == TW'(Y_T - 1)) state_d = StAllRed;
      StAllRed: if (cnt == TW'(AR_T - 1)) state_d = ped_pend_q ? StWalk : StGreen;
      StWalk:   if (cnt == TW'(WALK_T - 1)) state_d = StGreen;
      default:  state_d = StGreen;
    endcase

    cnt_clr     = (state_d != state_q);
    enter_green = (state_d == StGreen) && (state_q != StGreen);
    enter_walk  = (state_d == StWalk) && (state_q != StWalk);

    cur_d = cur_q;
    if (enter_green) cur_d = next_idx;

    pend_d = pend_q | (req & ~((state_q == StGreen) ? cur_mask : '0));
    if (enter_green) pend_d[next_idx] = 1'b0;

    ped_pend_d = ped_pend_q | (ped_req & (state_q != StWalk));
    if (enter_walk) ped_pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StGreen;
      cur_q      <= PW'(HomeIdx);
      pend_q     <= '0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    green  = (state_q == StGreen) ? cur_mask : '0;
    yellow = (state_q == StYellow) ? cur_mask : '0;
    red    = ~(green | yellow);
    walk   = (state_q == StWalk);
    phase  = cur_q;
  end

endmodule
